// File: rtl/munoc_input_route_unit_pkg.sv
// Shared definitions for the router input route unit: FSM state encoding
// and the layout of the sideband bits stored alongside each buffered flit.
package munoc_input_route_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROUTED = 2'd1,
        ST_DROP   = 2'd2
    } route_state_t;

    // Buffered word layout: {payload, tail, head}
    localparam int SB_HEAD  = 0;
    localparam int SB_TAIL  = 1;
    localparam int SB_WIDTH = 2;

endpackage

// File: rtl/munoc_flit_fifo.sv
// Synchronous flit FIFO with full/empty flags. Pointers carry one extra
// wrap bit so that full and empty can be told apart without a counter.
// Read data is the current head entry, available combinationally.
module munoc_flit_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    // Pointer update; push is refused when full, pop is refused when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/munoc_input_route_unit.sv
// Router input stage: buffers flits, presents the head flit's target node
// to the routing table, latches the one-hot route for the whole packet and
// requests the switch allocator until the tail flit is granted.
//
// state  | meaning
// IDLE   | waiting for a head flit at the FIFO head; computes its route
// ROUTED | route latched; requesting the allocator until the tail is granted
// DROP   | bad route seen; discarding flits up to and including the tail
module munoc_input_route_unit
    import munoc_input_route_unit_pkg::*;
#(
    parameter int BW_FLIT     = 32,
    parameter int BW_NODE_ID  = 1,
    parameter int NODE_ID_LSB = 0,
    parameter int NUM_OUTPUT  = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BW_FLIT-1:0]    in_data,
    input  logic                  in_head,
    input  logic                  in_tail,
    output logic [BW_NODE_ID-1:0] target_node,
    input  logic [NUM_OUTPUT-1:0] routing_info,
    output logic [NUM_OUTPUT-1:0] out_request,
    input  logic                  out_grant,
    output logic [BW_FLIT-1:0]    out_data,
    output logic                  out_head,
    output logic                  out_tail,
    output logic                  route_error
);

    localparam int FW = BW_FLIT + SB_WIDTH;

    route_state_t          state;
    logic [NUM_OUTPUT-1:0] route_reg;
    logic [FW-1:0]         fifo_wdata;
    logic [FW-1:0]         fifo_rdata;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  route_ok;

    function automatic logic is_onehot(input logic [NUM_OUTPUT-1:0] v);
        int cnt;
        cnt = 0;
        for (int i = 0; i < NUM_OUTPUT; i++) begin
            cnt += int'(v[i]);
        end
        return (cnt == 1);
    endfunction

    // Input is blocked while full even if a pop happens the same cycle,
    // and during the reset cycle itself.
    assign in_ready  = !fifo_full && !rst;
    assign fifo_push = in_valid && in_ready;

    // Pack payload and sideband flags into one buffered word.
    always_comb begin
        fifo_wdata                     = '0;
        fifo_wdata[SB_HEAD]            = in_head;
        fifo_wdata[SB_TAIL]            = in_tail;
        fifo_wdata[SB_WIDTH +: BW_FLIT] = in_data;
    end

    munoc_flit_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_data    = fifo_rdata[SB_WIDTH +: BW_FLIT];
    assign out_head    = fifo_rdata[SB_HEAD];
    assign out_tail    = fifo_rdata[SB_TAIL];
    assign target_node = out_data[NODE_ID_LSB +: BW_NODE_ID];
    assign route_ok    = is_onehot(routing_info);
    assign out_request = (state == ST_ROUTED && !fifo_empty) ? route_reg : '0;

    // Pop decision: granted flits, dropped packets and stray non-head flits.
    always_comb begin
        fifo_pop = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (!out_head) begin
                        fifo_pop = 1'b1;
                    end else if (!route_ok && out_tail) begin
                        fifo_pop = 1'b1;
                    end
                end
            end
            ST_ROUTED: begin
                if (out_grant && (out_request != '0)) begin
                    fifo_pop = 1'b1;
                end
            end
            ST_DROP: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                end
            end
            default: fifo_pop = 1'b0;
        endcase
    end

    // Route FSM: latches the route on a good head, holds it until the tail leaves.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            route_reg   <= '0;
            route_error <= 1'b0;
        end else begin
            route_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        if (!out_head) begin
                            route_error <= 1'b1;
                        end else if (route_ok) begin
                            route_reg <= routing_info;
                            state     <= ST_ROUTED;
                        end else begin
                            route_error <= 1'b1;
                            // A bad single-flit packet is popped directly from IDLE.
                            if (!out_tail) begin
                                state <= ST_DROP;
                            end
                        end
                    end
                end
                ST_ROUTED: begin
                    if (fifo_pop && out_tail) begin
                        route_reg <= '0;
                        state     <= ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (fifo_pop && out_tail) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
